// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe game sequencer:
//   - cell codes (EMPTY / P1 / P2) and player constants
//   - square numbers (NO_SQUARE, SQUARE_1..SQUARE_9, row-major from top-left)
//   - FSM state encoding
//   - the 8-entry winning-line table and board-access helpers
// No ports (package).
// ---------------------------------------------------------------------------
package ttt_pkg;

  // Cell codes; 2'b11 is never written into the board.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam logic [3:0] NO_SQUARE = 4'd0;
  localparam logic [3:0] SQUARE_1  = 4'd1;
  localparam logic [3:0] SQUARE_2  = 4'd2;
  localparam logic [3:0] SQUARE_3  = 4'd3;
  localparam logic [3:0] SQUARE_4  = 4'd4;
  localparam logic [3:0] SQUARE_5  = 4'd5;
  localparam logic [3:0] SQUARE_6  = 4'd6;
  localparam logic [3:0] SQUARE_7  = 4'd7;
  localparam logic [3:0] SQUARE_8  = 4'd8;
  localparam logic [3:0] SQUARE_9  = 4'd9;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  // Line table: each entry packs three squares {a, b, c}.
  // Entries 0-2 rows top->bottom, 3-5 columns left->right,
  // 6 main diagonal, 7 anti-diagonal (matches the win_line bit order).
  function automatic logic [11:0] line_triple(input logic [2:0] line);
    case (line)
      3'd0:    return {SQUARE_1, SQUARE_2, SQUARE_3};
      3'd1:    return {SQUARE_4, SQUARE_5, SQUARE_6};
      3'd2:    return {SQUARE_7, SQUARE_8, SQUARE_9};
      3'd3:    return {SQUARE_1, SQUARE_4, SQUARE_7};
      3'd4:    return {SQUARE_2, SQUARE_5, SQUARE_8};
      3'd5:    return {SQUARE_3, SQUARE_6, SQUARE_9};
      3'd6:    return {SQUARE_1, SQUARE_5, SQUARE_9};
      3'd7:    return {SQUARE_3, SQUARE_5, SQUARE_7};
      default: return {SQUARE_1, SQUARE_2, SQUARE_3};
    endcase
  endfunction

  // LSB position of square sq (1..9) in the packed 18-bit board.
  function automatic logic [4:0] cell_lsb(input logic [3:0] sq);
    return {sq, 1'b0} - 5'd2;
  endfunction

  function automatic logic [1:0] cell_at(input logic [17:0] board,
                                         input logic [3:0]  sq);
    return board[cell_lsb(sq) +: 2];
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// ---------------------------------------------------------------------------
// ttt_line_check
// Purely combinational: flags every line of the board fully owned by the
// given player code.
//   board    in  18  packed cells, square k at [2k-1:2k-2]
//   player   in  2   cell code to test (EMPTY never produces a hit)
//   line_hit out 8   one bit per line, same order as the package line table
// ---------------------------------------------------------------------------
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  player,
  output logic [7:0]  line_hit
);

  // Evaluate all eight lines against the player's code.
  always_comb begin
    line_hit = 8'd0;
    for (int l = 0; l < 8; l++) begin
      logic [11:0] trip;
      trip = line_triple(3'(l));
      line_hit[l] = (player != EMPTY) &&
                    (cell_at(board, trip[11:8]) == player) &&
                    (cell_at(board, trip[7:4])  == player) &&
                    (cell_at(board, trip[3:0])  == player);
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Tic-tac-toe game sequencer: holds the board, alternates turns, accepts or
// rejects moves, and detects win / draw. All outputs come straight from flops.
//   clk            in   system clock
//   clr            in   asynchronous active-high reset
//   enter          in   one-cycle move strobe
//   new_game       in   one-cycle strobe, clears the game (beats enter)
//   square_num     in   cursor square, 1..9 valid
//   square_status  out  packed board, square k at [2k-1:2k-2]
//   player_turn    out  player to move (0 = P1, 1 = P2)
//   player_1_win / player_2_win / draw  out  sticky results
//   game_over      out  high while in OVER
//   win_line       out  one-hot (or multi-hot on forks) winning lines
//   move_count     out  accepted moves this game
//   reject         out  one-cycle pulse for an ignored enter
// ---------------------------------------------------------------------------
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   SQ_W         = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            enter,
  input  logic            new_game,
  input  logic [SQ_W-1:0] square_num,
  output logic [17:0]     square_status,
  output logic            player_turn,
  output logic            player_1_win,
  output logic            player_2_win,
  output logic            draw,
  output logic            game_over,
  output logic [7:0]      win_line,
  output logic [3:0]      move_count,
  output logic            reject
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic        turn_q, turn_d;
  logic        p1_win_q, p1_win_d;
  logic        p2_win_q, p2_win_d;
  logic        draw_q, draw_d;
  logic        over_q, over_d;
  logic [7:0]  win_line_q, win_line_d;
  logic [3:0]  count_q, count_d;
  logic        reject_q, reject_d;

  logic        sq_valid_s;
  logic [3:0]  sel_sq_s;
  logic [1:0]  mover_code_s;
  logic [7:0]  line_hit_s;

  // Out-of-range squares are clamped to a legal index so the board read
  // never leaves the 18-bit vector; sq_valid_s still blocks the write.
  assign sq_valid_s   = (square_num >= SQ_W'(SQUARE_1)) &&
                        (square_num <= SQ_W'(SQUARE_9));
  assign sel_sq_s     = sq_valid_s ? square_num[3:0] : SQUARE_1;
  // player_turn still holds the mover during CHECK (toggle happens on exit).
  assign mover_code_s = turn_q ? P2 : P1;

  ttt_line_check u_line_check (
    .board    (board_q),
    .player   (mover_code_s),
    .line_hit (line_hit_s)
  );

  // Next-state and next-output logic for the PLAY/CHECK/OVER sequencer.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    p1_win_d   = p1_win_q;
    p2_win_d   = p2_win_q;
    draw_d     = draw_q;
    over_d     = over_q;
    win_line_d = win_line_q;
    count_d    = count_q;
    reject_d   = 1'b0;

    if (new_game) begin
      // Any simultaneous enter is dropped silently.
      state_d    = ST_PLAY;
      board_d    = 18'd0;
      turn_d     = FIRST_PLAYER;
      p1_win_d   = 1'b0;
      p2_win_d   = 1'b0;
      draw_d     = 1'b0;
      over_d     = 1'b0;
      win_line_d = 8'd0;
      count_d    = 4'd0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (enter) begin
            if (sq_valid_s && (cell_at(board_q, sel_sq_s) == EMPTY)) begin
              board_d[cell_lsb(sel_sq_s) +: 2] = mover_code_s;
              count_d = count_q + 4'd1;
              state_d = ST_CHECK;
            end else begin
              reject_d = 1'b1;
            end
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_CHECK: begin
          reject_d = enter;
          if (line_hit_s != 8'd0) begin
            // Win is checked before the draw so a 9th-move line wins.
            if (turn_q == PLAYER_2) begin
              p2_win_d = 1'b1;
            end else begin
              p1_win_d = 1'b1;
            end
            win_line_d = line_hit_s;
            over_d     = 1'b1;
            state_d    = ST_OVER;
          end else if (count_q == 4'd9) begin
            draw_d  = 1'b1;
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = ST_PLAY;
          end
        end
        ST_OVER: begin
          reject_d = enter;
          state_d  = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_PLAY;
      board_q    <= 18'd0;
      turn_q     <= FIRST_PLAYER;
      p1_win_q   <= 1'b0;
      p2_win_q   <= 1'b0;
      draw_q     <= 1'b0;
      over_q     <= 1'b0;
      win_line_q <= 8'd0;
      count_q    <= 4'd0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      p1_win_q   <= p1_win_d;
      p2_win_q   <= p2_win_d;
      draw_q     <= draw_d;
      over_q     <= over_d;
      win_line_q <= win_line_d;
      count_q    <= count_d;
      reject_q   <= reject_d;
    end
  end

  assign square_status = board_q;
  assign player_turn   = turn_q;
  assign player_1_win  = p1_win_q;
  assign player_2_win  = p2_win_q;
  assign draw          = draw_q;
  assign game_over     = over_q;
  assign win_line      = win_line_q;
  assign move_count    = count_q;
  assign reject        = reject_q;

endmodule
